// File: rtl/sort10_frame_ctrl.sv
// sort10_frame_ctrl: shares one 10-input combinational sort network between
// two streaming requesters, one whole frame at a time.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   reqN_valid/ready     per-requester word handshake (N = 0, 1)
//   reqN_data/last       word payload and end-of-frame marker
//   net_in / net_out     packed slots to / from the shared sort network
//   out_valid/ready      sorted-word handshake towards downstream
//   out_data/last/id     sorted word, end-of-frame marker, source requester
//   busy                 controller is not idle
module sort10_frame_ctrl #(
    parameter int                DATA_W = 32,
    parameter int                N      = 10,
    parameter logic [DATA_W-1:0] PAD    = {DATA_W{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_W-1:0]     req0_data,
    input  logic                  req0_last,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_W-1:0]     req1_data,
    input  logic                  req1_last,
    output logic [N*DATA_W-1:0]   net_in,
    input  logic [N*DATA_W-1:0]   net_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  out_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        DRAIN
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    state_e                       state_q;
    logic [N-1:0][DATA_W-1:0]     in_bank_q;
    logic [N-1:0][DATA_W-1:0]     out_bank_q;
    logic [3:0]                   cnt_q;
    logic [3:0]                   ptr_q;
    logic [3:0]                   len_q;
    logic                         gnt_q;
    logic                         last_grant_q;
    logic                         rdy0_q;
    logic                         rdy1_q;
    logic                         busy_q;
    logic                         ovalid_q;
    logic [DATA_W-1:0]            odata_q;
    logic                         olast_q;
    logic                         oid_q;

    logic                         gnt_d;
    logic [3:0]                   ptr_d;
    logic                         in_valid;
    logic [DATA_W-1:0]            in_data;
    logic                         in_last;
    logic                         in_hs;
    logic                         out_hs;

    always_comb begin
        // A tie goes to whoever did not win last time; otherwise the
        // single valid requester wins (req0 if neither, unused then).
        gnt_d    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        ptr_d    = ptr_q + 4'd1;
        in_valid = gnt_q ? req1_valid : req0_valid;
        in_data  = gnt_q ? req1_data : req0_data;
        in_last  = gnt_q ? req1_last : req0_last;
        in_hs    = in_valid && (gnt_q ? rdy1_q : rdy0_q);
        out_hs   = ovalid_q && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            in_bank_q    <= {N{PAD}};
            out_bank_q   <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            len_q        <= '0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rdy0_q       <= 1'b0;
            rdy1_q       <= 1'b0;
            busy_q       <= 1'b0;
            ovalid_q     <= 1'b0;
            odata_q      <= '0;
            olast_q      <= 1'b0;
            oid_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        gnt_q        <= gnt_d;
                        last_grant_q <= gnt_d;
                        rdy0_q       <= ~gnt_d;
                        rdy1_q       <= gnt_d;
                        busy_q       <= 1'b1;
                        state_q      <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        in_bank_q[cnt_q] <= in_data;
                        cnt_q            <= cnt_q + 4'd1;
                        // A full bank closes the frame even without last.
                        if (in_last || cnt_q == LAST_IDX) begin
                            rdy0_q  <= 1'b0;
                            rdy1_q  <= 1'b0;
                            state_q <= SORT;
                        end
                    end
                end
                SORT: begin
                    // Unused slots hold PAD, so the real words land in
                    // the lowest len slots of the network output.
                    out_bank_q <= net_out;
                    len_q      <= cnt_q;
                    ptr_q      <= '0;
                    ovalid_q   <= 1'b1;
                    odata_q    <= net_out[DATA_W-1:0];
                    olast_q    <= (cnt_q == 4'd1);
                    oid_q      <= gnt_q;
                    state_q    <= DRAIN;
                end
                DRAIN: begin
                    if (out_hs) begin
                        ptr_q <= ptr_d;
                        if (olast_q) begin
                            in_bank_q <= {N{PAD}};
                            cnt_q     <= '0;
                            ovalid_q  <= 1'b0;
                            odata_q   <= '0;
                            olast_q   <= 1'b0;
                            oid_q     <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            odata_q <= out_bank_q[ptr_d];
                            olast_q <= (ptr_d == len_q - 4'd1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign net_in     = in_bank_q;
    assign req0_ready = rdy0_q;
    assign req1_ready = rdy1_q;
    assign out_valid  = ovalid_q;
    assign out_data   = odata_q;
    assign out_last   = olast_q;
    assign out_id     = oid_q;
    assign busy       = busy_q;

endmodule

// File: doc/sort10_frame_ctrl.md
# sort10_frame_ctrl

Frame-level controller that shares one 10-input, 32-bit combinational sort network between two streaming requesters. It arbitrates per frame (round-robin) and collects up to 10 words from the granted requester into a register bank. It drives the bank onto the network for one capture cycle, then streams the sorted words back out with the requester ID. It sits between upstream packet sources and the shared sorter instance.

## Interface
- DATA_W, 32, word width (network width fixed at 32).
- N, 10, words per frame (fixed; network size).
- PAD, {DATA_W{1'b1}}, fill value for unused slots of short frames.

- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- req0_valid  in  1  requester 0 word valid.
- req0_ready  out  1  requester 0 word accepted when valid&ready.
- req0_data  in  32  requester 0 word.
- req0_last  in  1  requester 0 final word of frame.
- req1_valid / req1_ready / req1_data / req1_last: same for requester 1.
- net_in  out  320  to sort network; slot i at [32i+31:32i].
- net_out  in  320  from sort network; slot 0 = smallest.
- out_valid  out  1  sorted word valid.
- out_ready  in  1  downstream accepts when out_valid&out_ready.
- out_data  out  32  sorted word, ascending order.
- out_last  out  1  final sorted word of frame.
- out_id  out  1  requester that supplied the frame.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, SORT, DRAIN.
- IDLE: in_bank slots all PAD, cnt=0. If any reqX_valid, grant the requester and go to LOAD.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant !last_grant. last_grant resets to 1, so requester 0 wins the first tie.
  - Grant is registered as gnt and last_grant<=gnt.
- LOAD: only reqG_ready is high (G=gnt), and it stays high for the whole state. The other requester's ready is 0.
  - On each handshake: in_bank[cnt]<=data, cnt<=cnt+1.
  - Go to SORT when the handshake carries last, or when it is the 10th word (cnt==9) regardless of last.
  - A word arriving after the 10th starts a new frame and goes back through arbitration.
- SORT (1 cycle): net_in = in_bank, which is driven continuously in all states. out_bank<=net_out; len<=cnt; ptr<=0. Go to DRAIN.
- DRAIN: out_valid=1, out_data=out_bank[ptr], out_last=(ptr==len-1), out_id=gnt.
  - On each handshake ptr<=ptr+1.
  - On the handshake with out_last: clear in_bank to PAD, cnt<=0, go to IDLE.
- Short frames: the len real words are the smallest len network outputs, because PAD is the maximum value. Only those len words are emitted. Real words equal to PAD sort identically, so output is still correct.
- cnt and ptr are 4 bits; len ranges 1..10. A zero-length frame cannot occur.
- Comparisons are unsigned.
- Reset, including mid-frame or mid-drain:
  - state=IDLE, cnt=0, ptr=0, len=0, gnt=0, last_grant=1, in_bank=PAD, out_bank=0.
  - The partial frame is discarded.
- Output reset values: req0_ready=0, req1_ready=0, out_valid=0, out_data=0, out_last=0, out_id=0, busy=0, net_in=all PAD.
- Outside DRAIN, out_data/out_last/out_id are held at 0.

## Timing
- IDLE→LOAD: 1 cycle after valid is first seen. The first word can be accepted in the cycle after the grant.
- Final input handshake at cycle t: SORT at t+1, first out_valid at t+2.
- With out_ready held high, one word per cycle; the frame finishes at t+1+len.
- No overlap: both ready signals are 0 in SORT, DRAIN and IDLE. Minimum frame period is 1+len_in+1+len_out cycles.
- out_valid, once high, stays high with out_data stable until accepted.
- Round-robin holds under continuous contention: grants alternate 0,1,0,1.
- The network is purely combinational. It is given exactly one cycle from in_bank registers to out_bank registers.

## Test plan
- Single full frame, req0: 9,3,7,0,5,1,8,2,6,4 with last on the 10th word → out 0..9 ascending, out_last on 9, out_id=0, first out_valid 2 cycles after the final input.
- Short frame, req1: 3 words 0xFFFFFFFF,5,2 with last → out 2,5,0xFFFFFFFF, out_last on the third word, out_id=1, exactly 3 output handshakes.
- Contention: both requesters always valid with 2-word frames → grants alternate 0,1,0,1 starting with 0. The non-granted ready stays 0 throughout.
- Overlong frame: req0 sends 12 words with no last before the 12th → first frame closes after 10 words. Words 11–12 form a second frame of 2 words.
- Output backpressure: out_ready toggles 1,0,0,1… during DRAIN → out_data/out_last are stable while stalled, no words lost or duplicated, both readys stay 0.
- Reset mid-LOAD after 4 words, then a fresh 2-word frame 7,1 → all outputs at reset values the cycle after rst; output is 1,7 only, with no stale data.
